// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester arbiter in front of a shared single-cycle ALU
//
// Purpose:
//   Arbitrates between two requesters for one single-cycle ALU. The winning
//   operation is registered onto the ALU drive outputs for one EXEC cycle.
//   The ALU result and zero flag are captured at the end of that cycle.
//   They are then returned to the winner through a valid/ready response.
//   The opcode is forwarded undecoded, so the ALU owns the operation encoding.
//
// Configuration macro:
//   ALU_ARB_FIXED_PRIO_EN - when defined, requester 0 always wins contention.
//                           When undefined, contention is resolved round-robin.
//
// Ports:
//   clk, reset                   rising-edge clock, synchronous active-high reset
//   req{0,1}_valid_i / _ready_o  request handshake per requester
//   req{0,1}_op_i, _a_i, _b_i    opcode and operands per requester
//   resp{0,1}_valid_o / _ready_i response handshake per requester
//   resp_result_o, resp_zero_o   captured ALU result/zero, shared by both responses
//   alu_op_o, alu_a_o, alu_b_o   registered drive to the ALU
//   alu_result_i, alu_zero_i     ALU outputs, sampled at the end of EXEC

module alu_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int OP_WIDTH   = 4
) (
   input  logic                  clk,
   input  logic                  reset,

   input  logic                  req0_valid_i,
   output logic                  req0_ready_o,
   input  logic [OP_WIDTH-1:0]   req0_op_i,
   input  logic [DATA_WIDTH-1:0] req0_a_i,
   input  logic [DATA_WIDTH-1:0] req0_b_i,

   input  logic                  req1_valid_i,
   output logic                  req1_ready_o,
   input  logic [OP_WIDTH-1:0]   req1_op_i,
   input  logic [DATA_WIDTH-1:0] req1_a_i,
   input  logic [DATA_WIDTH-1:0] req1_b_i,

   output logic                  resp0_valid_o,
   input  logic                  resp0_ready_i,
   output logic                  resp1_valid_o,
   input  logic                  resp1_ready_i,
   output logic [DATA_WIDTH-1:0] resp_result_o,
   output logic                  resp_zero_o,

   output logic [OP_WIDTH-1:0]   alu_op_o,
   output logic [DATA_WIDTH-1:0] alu_a_o,
   output logic [DATA_WIDTH-1:0] alu_b_o,
   input  logic [DATA_WIDTH-1:0] alu_result_i,
   input  logic                  alu_zero_i
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t                state_q,      state_d;
   logic                  owner_q,      owner_d;
   logic                  last_grant_q, last_grant_d;
   logic [OP_WIDTH-1:0]   alu_op_q,     alu_op_d;
   logic [DATA_WIDTH-1:0] alu_a_q,      alu_a_d;
   logic [DATA_WIDTH-1:0] alu_b_q,      alu_b_d;
   logic [DATA_WIDTH-1:0] result_q,     result_d;
   logic                  zero_q,       zero_d;

   // Requester index that would be accepted this cycle (0 or 1).
   logic                  grant;
   logic                  grant_valid;
   logic                  accept;
   logic                  owner_resp_ready;

   // ------------------------------------------------------------------
   // Grant selection: depends only on the two valids and last_grant_q,
   // never on the opcode or operands.
   // ------------------------------------------------------------------
`ifdef ALU_ARB_FIXED_PRIO_EN
   // Requester 0 has absolute priority. last_grant_q is still maintained
   // so that the register state is identical in both builds.
   always_comb begin
      grant = 1'b1;
      if (req0_valid_i) begin
         grant = 1'b0;
      end
   end
`else
   // Round-robin: under contention the requester that did not win last
   // time goes next. last_grant_q resets to 1 so requester 0 wins first.
   always_comb begin
      grant = 1'b1;
      if (req0_valid_i && req1_valid_i) begin
         grant = ~last_grant_q;
      end else if (req0_valid_i) begin
         grant = 1'b0;
      end
   end
`endif

   assign grant_valid = grant ? req1_valid_i : req0_valid_i;
   assign accept      = (state_q == IDLE) && grant_valid;

   // Ready is gated with reset, so a request is never presented as accepted
   // during the reset cycle, even though the state register updates only at the edge.
   assign req0_ready_o = !reset && (state_q == IDLE) && !grant && req0_valid_i;
   assign req1_ready_o = !reset && (state_q == IDLE) &&  grant && req1_valid_i;

   assign resp0_valid_o = !reset && (state_q == RESP) && !owner_q;
   assign resp1_valid_o = !reset && (state_q == RESP) &&  owner_q;

   // Only the owner's ready completes the response; the other is ignored.
   assign owner_resp_ready = owner_q ? resp1_ready_i : resp0_ready_i;

   // ------------------------------------------------------------------
   // Next-state and datapath load logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      alu_op_d     = alu_op_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      result_d     = result_q;
      zero_d       = zero_q;

      unique case (state_q)
         IDLE: begin
            if (accept) begin
               owner_d      = grant;
               last_grant_d = grant;
               if (grant) begin
                  alu_op_d = req1_op_i;
                  alu_a_d  = req1_a_i;
                  alu_b_d  = req1_b_i;
               end else begin
                  alu_op_d = req0_op_i;
                  alu_a_d  = req0_a_i;
                  alu_b_d  = req0_b_i;
               end
               state_d = EXEC;
            end
         end

         EXEC: begin
            // The ALU sees stable registered inputs for this whole cycle;
            // its outputs are captured at the closing edge.
            result_d = alu_result_i;
            zero_d   = alu_zero_i;
            state_d  = RESP;
         end

         RESP: begin
            if (owner_resp_ready) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         owner_q      <= 1'b0;
         last_grant_q <= 1'b1;
         alu_op_q     <= '0;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         result_q     <= '0;
         zero_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         alu_op_q     <= alu_op_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         result_q     <= result_d;
         zero_q       <= zero_d;
      end
   end

   assign alu_op_o      = alu_op_q;
   assign alu_a_o       = alu_a_q;
   assign alu_b_o       = alu_b_q;
   assign resp_result_o = result_q;
   assign resp_zero_o   = zero_q;

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single-cycle 32-bit ALU between two requesters, for example the main execute datapath and a branch/address helper unit. The block arbitrates between them and registers the selected operation into the ALU. It captures the ALU result and zero flag, then returns them to the winning requester through a valid/ready response handshake. The ALU opcode is passed through without being decoded, so the ALU's operation encoding stays the single source of truth.

## Interface
- DATA_WIDTH, 32, operand and result width.
- OP_WIDTH, 4, ALU operation code width.

- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req0_valid_i / req1_valid_i  input  1  requester n presents an operation.
- req0_ready_o / req1_ready_o  output  1  arbiter accepts requester n's operation this cycle.
- req0_op_i / req1_op_i  input  OP_WIDTH  ALU operation code.
- req0_a_i / req1_a_i, req0_b_i / req1_b_i  input  DATA_WIDTH  operands A and B.
- resp0_valid_o / resp1_valid_o  output  1  result available for requester n.
- resp0_ready_i / resp1_ready_i  input  1  requester n consumes the result.
- resp_result_o  output  DATA_WIDTH  captured ALU result, shared by both responses.
- resp_zero_o  output  1  captured ALU zero flag.
- alu_op_o  output  OP_WIDTH  opcode driven to the ALU.
- alu_a_o, alu_b_o  output  DATA_WIDTH  operands driven to the ALU.
- alu_result_i  input  DATA_WIDTH  ALU result.
- alu_zero_i  input  1  ALU zero flag.

## Operation
- The FSM has three states: IDLE, EXEC, RESP. The reset state is IDLE.
- **IDLE state**
  - Grant is computed combinationally from the two valids and the last_grant register.
  - Exactly one req*_ready_o is high: the one for the granted requester, and only if that requester's valid is high.
  - Acceptance occurs when valid && ready is true for the granted requester. On acceptance:
    - op, A and B are registered into the ALU-drive registers;
    - owner is set to the granted requester;
    - last_grant is set to the granted requester;
    - the FSM moves to EXEC.
- **Round-robin grant** (default build)
  - Only one valid high: grant that requester.
  - Both valid high: grant the requester that is not last_grant.
  - last_grant resets to 1, so requester 0 wins the first contention.
- **EXEC state** lasts exactly one cycle.
  - alu_*_o are stable from the registers.
  - At the end of the cycle, alu_result_i and alu_zero_i are captured into resp_result_o and resp_zero_o.
  - The FSM moves to RESP.
- **RESP state**
  - resp<owner>_valid_o is high. The other response valid stays 0.
  - The FSM holds in RESP until resp<owner>_ready_i is high; on that handshake it returns to IDLE.
  - resp<other>_ready_i is ignored.
- alu_*_o and resp_result_o/resp_zero_o hold their last value outside of load and capture. They are not cleared on return to IDLE.
- No new request is accepted while the FSM is in EXEC or RESP. Both req*_ready_o are 0 in those states.
- Opcodes the ALU does not implement are forwarded unchanged. The arbiter returns whatever the ALU produces.

## Timing
- **Reset**
  - While reset is high: both req*_ready_o = 0 and both resp*_valid_o = 0.
  - After reset: alu_op_o = 0, alu_a_o = 0, alu_b_o = 0, resp_result_o = 0, resp_zero_o = 0.
  - After reset: state = IDLE, owner = 0, last_grant = 1.
- **Latency**
  - Acceptance happens at edge N.
  - The ALU inputs are valid in cycle N+1 (EXEC).
  - resp*_valid_o is high from cycle N+2.
- **Throughput**: at most one operation per 3 cycles. A response handshake and a new acceptance never happen in the same cycle.
- **Ready behaviour**: req*_ready_o does not depend on req*_op/a/b. It depends on state, last_grant and both valids.
- **Valid withdrawal**: if a requester drops valid while in IDLE before being accepted, nothing is recorded.
- **Reset mid-operation** (in EXEC or RESP): the operation is abandoned. No response is issued, and all registers take their reset values.
- **Response ready already high**: if resp<owner>_ready_i is high on RESP entry, the response lasts exactly one cycle.

## Configuration
- ALU_ARB_FIXED_PRIO_EN
  - Defined: requester 0 always wins when both valids are high. last_grant is still updated but does not affect the grant.
  - Undefined: round-robin as described in Operation.
  - All other behaviour and timing are identical in both builds.

## Test plan
- **Single request, requester 0**: after reset, drive op=0 (ADD), A=5, B=7, resp0_ready_i=1 from the start.
  - req0_ready_o=1 at N.
  - alu_a_o=5 and alu_b_o=7 at N+1.
  - resp0_valid_o=1 with result 12 and zero=0 at N+2 only.
  - resp1_valid_o stays 0.
- **Zero flag and response backpressure**: requester 1 drives op=1 (SUB), A=B=0x1234, with resp1_ready_i=0 for 4 cycles.
  - resp1_valid_o holds with result 0 and zero=1 until ready rises.
  - req0_ready_o and req1_ready_o stay 0 for the whole time.
- **Contention, round-robin (default build)**: both valids held high for 4 operations.
  - Grant order is 0, 1, 0, 1.
  - Each response goes to the matching requester and carries that requester's operands.
- **Contention with ALU_ARB_FIXED_PRIO_EN**: the same stimulus as the round-robin test.
  - Requester 0 is granted all 4 times.
  - req1_ready_o never rises.
- **Reset mid-operation**: assert reset for 1 cycle during RESP.
  - No response handshake completes.
  - All outputs read their reset values.
  - A subsequent request with A=0xFFFFFFFF, B=1, op ADD returns 0 with zero=1.
